if_stage_fetch: RTL and testbench

- Instruction fetch stage of the ARM pipeline. It produces the PC / instruction pair that the decode stage consumes.
- Holds the program counter and drives a req/ack handshake to instruction memory, which may have variable latency.
- Owns the IF/ID pipeline register and a one-entry skid buffer.
- Obeys decode-side freeze (hazard stall) and execute-side branch redirect (flush).

---
 rtl/if_stage_fetch.sv | 158 +++++++++++++++
 tb/tb_if_stage_fetch.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fetch.sv
// if_stage_fetch: instruction fetch stage. It holds the program counter, runs
// a req/ack handshake to instruction memory, owns the IF/ID register and a
// one-entry skid buffer, honours decode freeze and execute redirects.
// Optional build macro: IF_STAT_COUNTERS_EN adds fetch_count/bubble_count.
module if_stage_fetch #(
    parameter int unsigned                 ADDRESS_LEN     = 32,
    parameter int unsigned                 INSTRUCTION_LEN = 32,
    parameter logic [ADDRESS_LEN-1:0]      RESET_PC        = '0,
    parameter int unsigned                 PC_STEP         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       branch_taken,
    input  logic [ADDRESS_LEN-1:0]     branch_address,
    output logic                       imem_req,
    output logic [ADDRESS_LEN-1:0]     imem_addr,
    input  logic                       imem_ack,
    input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
    output logic [ADDRESS_LEN-1:0]     PC,
    output logic [INSTRUCTION_LEN-1:0] Instruction,
    output logic                       valid
`ifdef IF_STAT_COUNTERS_EN
    ,
    output logic [31:0]                fetch_count,
    output logic [31:0]                bubble_count
`endif
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [ADDRESS_LEN-1:0] STEP     = ADDRESS_LEN'(PC_STEP);
    localparam logic [ADDRESS_LEN-1:0] WORD_MSK = ~ADDRESS_LEN'(3);

    logic [1:0]                 state;
    logic [ADDRESS_LEN-1:0]     pc_reg;
    logic [ADDRESS_LEN-1:0]     pc_next;
    logic [ADDRESS_LEN-1:0]     pend_pc;
    logic [ADDRESS_LEN-1:0]     target;
    logic [ADDRESS_LEN-1:0]     skid_pc;
    logic [INSTRUCTION_LEN-1:0] skid_instr;

    // Handshake outputs: the address is the PC itself, so it cannot move
    // while a request is waiting for its ack.
    always_comb begin
        imem_req  = rst && (state != HOLD);
        imem_addr = pc_reg;
        pc_next   = pc_reg + STEP;
        target    = branch_address & WORD_MSK;
    end

    // PC, state machine, skid buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FETCH;
            pc_reg      <= RESET_PC;
            pend_pc     <= '0;
            skid_pc     <= '0;
            skid_instr  <= '0;
            PC          <= '0;
            Instruction <= '0;
            valid       <= 1'b0;
        end else if (branch_taken) begin
            // Redirect beats freeze; a still-open request must be drained
            // before the new target may be presented.
            valid       <= 1'b0;
            Instruction <= '0;
            skid_pc     <= '0;
            skid_instr  <= '0;
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        pc_reg <= target;
                    end else begin
                        pend_pc <= target;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        pc_reg <= target;
                        state  <= FETCH;
                    end else begin
                        pend_pc <= target;
                    end
                end
                default: begin
                    pc_reg <= target;
                    state  <= FETCH;
                end
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack && !freeze) begin
                        PC          <= pc_next;
                        Instruction <= imem_rdata;
                        valid       <= 1'b1;
                        pc_reg      <= pc_next;
                    end else if (imem_ack) begin
                        skid_instr <= imem_rdata;
                        skid_pc    <= pc_next;
                        pc_reg     <= pc_next;
                        state      <= HOLD;
                    end else if (!freeze) begin
                        valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        PC          <= skid_pc;
                        Instruction <= skid_instr;
                        valid       <= 1'b1;
                        state       <= FETCH;
                    end
                end
                DRAIN: begin
                    valid <= 1'b0;
                    if (imem_ack) begin
                        pc_reg <= pend_pc;
                        state  <= FETCH;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= FETCH;
                end
            endcase
        end
    end

`ifdef IF_STAT_COUNTERS_EN
    logic fetch_hit;
    logic bubble_load;

    // Classify the current cycle for the statistics counters.
    always_comb begin
        fetch_hit   = rst && !branch_taken && (state == FETCH) && imem_ack;
        bubble_load = rst && !freeze &&
                      (branch_taken || (state == DRAIN) ||
                       ((state == FETCH) && !imem_ack));
    end

    // Free-running wrapping statistics counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (fetch_hit)   fetch_count  <= fetch_count + 32'd1;
            if (bubble_load) bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch. Expected IF/ID contents are queued when
// each step is driven and popped after the following rising edge.
module tb_if_stage_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_out;
    logic [31:0] instr;
    logic        valid;

    logic        ack2 = 1'b0;
    logic [31:0] rd2 = '0;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = '0;
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] pc2;
    logic [31:0] instr2;
    logic        valid2;

`ifdef IF_STAT_COUNTERS_EN
    logic [31:0] fetch_count, bubble_count, fc2, bc2;
`endif

    int ncmp = 0;
    int nfail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    if_stage_fetch #(.ADDRESS_LEN(32), .INSTRUCTION_LEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_address(branch_address), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC(pc_out),
        .Instruction(instr), .valid(valid)
`ifdef IF_STAT_COUNTERS_EN
        , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
    );

    if_stage_fetch #(.ADDRESS_LEN(32), .INSTRUCTION_LEN(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut2 (
        .clk(clk), .rst(rst), .freeze(zero1), .branch_taken(zero1),
        .branch_address(zero32), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rd2), .PC(pc2),
        .Instruction(instr2), .valid(valid2)
`ifdef IF_STAT_COUNTERS_EN
        , .fetch_count(fc2), .bubble_count(bc2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reset for one edge; rst stays low until the next step releases it.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
        #1 chk("rst_req", {31'b0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_ins", instr, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
    endtask

    // One clock step: drive, check handshake outputs before the edge, queue
    // the expected IF/ID contents and compare them after the edge.
    task automatic cyc(input string tag, input logic fr, input logic br, input logic [31:0] ba,
                       input logic ak, input logic [31:0] rd,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic [31:0] e_pc, input logic [31:0] e_ins, input logic e_v);
        exp_t e;
        @(negedge clk);
        rst = 1'b1; freeze = fr; branch_taken = br; branch_address = ba;
        imem_ack = ak; imem_rdata = rd;
        #1;
        chk({tag, "_req"}, {31'b0, imem_req}, {31'b0, e_req});
        chk({tag, "_addr"}, imem_addr, e_addr);
        sb.push_back('{pc: e_pc, ins: e_ins, v: e_v});
        @(posedge clk);
        #1;
        chk({tag, "_sb_depth"}, sb.size(), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_pc"}, pc_out, e.pc);
            chk({tag, "_ins"}, instr, e.ins);
            chk({tag, "_valid"}, {31'b0, valid}, {31'b0, e.v});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 0-wait memory
        do_reset();
        cyc("zw0", 0, 0, 0, 1, 32'h0, 1, 32'h0, 32'h4, 32'h0, 1);
        cyc("zw1", 0, 0, 0, 1, 32'h4, 1, 32'h4, 32'h8, 32'h4, 1);
        cyc("zw2", 0, 0, 0, 1, 32'h8, 1, 32'h8, 32'hC, 32'h8, 1);

        // 2-cycle latency memory
        do_reset();
        cyc("lat0", 0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0, 32'h0, 0);
        cyc("lat1", 0, 0, 0, 1, 32'h0, 1, 32'h0, 32'h4, 32'h0, 1);
        cyc("lat2", 0, 0, 0, 0, 32'h0, 1, 32'h4, 32'h4, 32'h0, 0);
        cyc("lat3", 0, 0, 0, 1, 32'h4, 1, 32'h4, 32'h8, 32'h4, 1);

        // Freeze on the ack for 0x8: skid holds it, no request in HOLD
        do_reset();
        cyc("fz0", 0, 0, 0, 1, 32'h0, 1, 32'h0, 32'h4, 32'h0, 1);
        cyc("fz1", 0, 0, 0, 1, 32'h4, 1, 32'h4, 32'h8, 32'h4, 1);
        cyc("fz2", 1, 0, 0, 1, 32'h8, 1, 32'h8, 32'h8, 32'h4, 1);
        cyc("fz3", 1, 0, 0, 0, 32'h0, 0, 32'hC, 32'h8, 32'h4, 1);
        cyc("fz4", 1, 0, 0, 0, 32'h0, 0, 32'hC, 32'h8, 32'h4, 1);
        cyc("fz5", 0, 0, 0, 0, 32'h0, 0, 32'hC, 32'hC, 32'h8, 1);
        cyc("fz6", 0, 0, 0, 1, 32'hC, 1, 32'hC, 32'h10, 32'hC, 1);

        // Redirect to 0x103 while the 0x10 request is pending: drain, discard
        cyc("br0", 0, 1, 32'h103, 0, 32'h0, 1, 32'h10, 32'h10, 32'h0, 0);
        cyc("br1", 0, 0, 0, 0, 32'h0, 1, 32'h10, 32'h10, 32'h0, 0);
        cyc("br2", 1, 0, 0, 1, 32'hDEAD_BEEF, 1, 32'h10, 32'h10, 32'h0, 0);
        cyc("br3", 0, 0, 0, 0, 32'h0, 1, 32'h100, 32'h10, 32'h0, 0);
        cyc("br4", 0, 0, 0, 1, 32'hE100, 1, 32'h100, 32'h104, 32'hE100, 1);

        // Redirect together with freeze while in HOLD drops the skid entry
        cyc("hb0", 1, 0, 0, 1, 32'hE104, 1, 32'h104, 32'h104, 32'hE100, 1);
        cyc("hb1", 1, 1, 32'h200, 0, 32'h0, 0, 32'h108, 32'h104, 32'h0, 0);
        cyc("hb2", 0, 0, 0, 0, 32'h0, 1, 32'h200, 32'h104, 32'h0, 0);
        cyc("hb3", 0, 0, 0, 1, 32'hE200, 1, 32'h200, 32'h204, 32'hE200, 1);

        // Redirect on an ack cycle: word discarded, new target next
        cyc("ba0", 0, 1, 32'h301, 1, 32'hBAD0, 1, 32'h204, 32'h204, 32'h0, 0);
        cyc("ba1", 0, 0, 0, 1, 32'hE300, 1, 32'h300, 32'h304, 32'hE300, 1);
        cyc("ba2", 1, 0, 0, 0, 32'h0, 1, 32'h304, 32'h304, 32'hE300, 1);

`ifdef IF_STAT_COUNTERS_EN
        do_reset();
        chk("cnt_rst_fetch", fetch_count, 32'd0);
        chk("cnt_rst_bubble", bubble_count, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc("cnt_wait", 0, 0, 0, 0, 32'h0, 1, 32'(4 * i), 32'(4 * i),
                (i == 0) ? 32'h0 : 32'(4 * (i - 1)), 0);
            cyc("cnt_ack", 0, 0, 0, 1, 32'(4 * i), 1, 32'(4 * i), 32'(4 * i + 4), 32'(4 * i), 1);
        end
        chk("cnt_fetch", fetch_count, 32'd5);
        chk("cnt_bubble", bubble_count, 32'd5);
        do_reset();
        chk("cnt_clr_fetch", fetch_count, 32'd0);
        chk("cnt_clr_bubble", bubble_count, 32'd0);
`endif

        // PC wrap on the instance reset to 0xFFFFFFFC
        @(negedge clk);
        rst = 1'b1; ack2 = 1'b1; rd2 = 32'hAAAA_5555;
        #1;
        chk("wrap_req", {31'b0, req2}, 32'd1);
        chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        chk("wrap_pc", pc2, 32'h0);
        chk("wrap_ins", instr2, 32'hAAAA_5555);
        chk("wrap_valid", {31'b0, valid2}, 32'd1);
        chk("wrap_addr1", addr2, 32'h0);
        @(negedge clk);
        ack2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
